// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared types and helpers for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_MWAIT = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   localparam logic [4:0] REG_ZERO  = 5'd0;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // Opcodes whose ID-stage instruction sources the rt field.
   function automatic logic op_reads_rt(input logic [5:0] opcode);
      return (opcode == OPC_RTYPE) || (opcode == OPC_BEQ) || (opcode == OPC_SW);
   endfunction

   function automatic logic op_is_mem(input logic [5:0] opcode);
      return (opcode == OPC_LW) || (opcode == OPC_SW);
   endfunction

   function automatic logic op_is_ctrl(input logic [5:0] opcode);
      return (opcode == OPC_BEQ) || (opcode == OPC_J);
   endfunction

   // $0 is hardwired, so it can never be the source of a dependency.
   function automatic logic reg_match(input logic [4:0] r,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
// ============================================================================
// Module : hazard_sat_counter
// Brief  : Saturating event counter, cleared only by reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Stall/flush sequencer for the 5-stage pipe; event counters are
//          built only when HAZARD_PERF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             id_branch_i,
   input  logic             id_jump_i,
   input  logic             branch_taken_i,
   input  logic             ex_memread_i,
   input  logic             ex_regwrite_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             mem_memread_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_access_i,
   input  logic             dmem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_hold_o,
   output logic             stall_o,
   output logic             flush_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   localparam int               WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic w_mwait;
   logic w_load_use;
   logic w_br_dep;
   logic w_stall;
   logic w_flush;

   assign w_mwait    = mem_access_i & ~dmem_ready_i;
   assign w_load_use = ex_memread_i & reg_match(ex_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);
   assign w_br_dep   = id_branch_i &
                       ((ex_regwrite_i & reg_match(ex_rd_i, id_rs_i, id_rt_i, id_uses_rt_i)) |
                        (mem_memread_i & reg_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rt_i)));
   assign w_stall    = w_load_use | w_br_dep;
   assign w_flush    = ~w_stall & (id_jump_i | (id_branch_i & branch_taken_i));

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_hold_o   = 1'b1;
      stall_o       = 1'b0;
      flush_o       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_MWAIT: begin
            pipe_hold_o = 1'b0;
            if (w_mwait) begin
               pipe_hold_o = 1'b1;
            end else if (w_stall) begin
               idex_bubble_o = 1'b1;
               stall_o       = 1'b1;
            end else if (w_flush) begin
               // IF/ID stays write-enabled so the flush can load its nop.
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
               ifid_flush_o = 1'b1;
               flush_o      = 1'b1;
            end else begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
            end

            // Every consecutive wait cycle counts, including the first one seen in RUN.
            if (!start_i) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (w_mwait) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               state_d    = (wait_cnt_d == TIMEOUT_V) ? ST_ERR : ST_MWAIT;
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign err_o = (state_q == ST_ERR);

`ifdef HAZARD_PERF_EN
   hazard_sat_counter #(
      .CNT_W   (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall_o),
      .count_o (stall_cnt_o)
   );

   hazard_sat_counter #(
      .CNT_W   (CNT_W)
   ) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (flush_o),
      .count_o (flush_cnt_o)
   );
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire
